cfd_run_ctrl: RTL and testbench

Multi-channel run controller for the CFD kernel array. It launches up to NCH kernel instances with the `run_req`/`run_busy` handshake, repeats the launch for a programmable number of time-step iterations, and reports the total elapsed cycle count. It replaces the ad-hoc single-kernel launch-and-count sequence and sits between the host/command logic and the kernel instances.

---
 rtl/cfd_run_ctrl.sv | 136 +++++++++++++
 tb/tb_cfd_run_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfd_run_ctrl.sv
// rtl/cfd_run_ctrl.sv - multi-channel kernel launch/iterate controller with elapsed-cycle count
// Optional WAIT watchdog: define RUN_CTRL_WATCHDOG_EN.
module cfd_run_ctrl #(
    parameter int NCH     = 4,
    parameter int ITER_W  = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              i_start,
    input  logic [ITER_W-1:0] i_iter,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_cycles,
    output logic [ITER_W-1:0] o_iter,
    output logic [NCH-1:0]    o_run_req,
    input  logic [NCH-1:0]    i_run_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] iter_lat;
    logic [ITER_W-1:0] iter_inc;
    logic [NCH-1:0]    seen_mask;
    logic [CNT_W-1:0]  cycles_inc;
    logic              seen_full;
    logic              exit_ok;
    logic              last_iter;
    logic              timeout_hit;

    // A channel counts as finished once it has been seen busy and is now idle
    assign seen_full  = &seen_mask;
    assign exit_ok    = seen_full && (i_run_busy == '0);
    assign iter_inc   = o_iter + 1'b1;
    assign last_iter  = !(iter_inc < iter_lat);
    assign cycles_inc = (&o_cycles) ? o_cycles : o_cycles + 1'b1;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign timeout_hit = (state == S_WAIT) && !seen_full &&
                         (wd_cnt == WD_W'(TIMEOUT - 1));
    assign o_err       = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE:   if (i_start) err_q <= 1'b0;
                S_LAUNCH: wd_cnt <= '0;
                S_WAIT: begin
                    if (!seen_full) wd_cnt <= wd_cnt + 1'b1;
                    if (timeout_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            iter_lat  <= '0;
            o_cycles  <= '0;
            o_iter    <= '0;
            seen_mask <= '0;
        end else if (ce) begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        iter_lat <= i_iter;
                        o_cycles <= '0;
                        o_iter   <= '0;
                    end
                end
                S_LAUNCH: begin
                    seen_mask <= '0;
                    o_cycles  <= cycles_inc;
                end
                S_WAIT: begin
                    seen_mask <= seen_mask | i_run_busy;
                    o_cycles  <= cycles_inc;
                    if (exit_ok) o_iter <= iter_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        o_run_req = '0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = (i_iter == '0) ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH: begin
                o_run_req = '1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (exit_ok)          state_nxt = last_iter ? S_DONE : S_LAUNCH;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cfd_run_ctrl.sv
// tb/tb_cfd_run_ctrl.sv - directed bench for cfd_run_ctrl with per-channel kernel models
module tb_cfd_run_ctrl;

    localparam int NCH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ce;
    logic        i_start;
    logic [15:0] i_iter;

    logic        busy, done, err;
    logic [31:0] cycles;
    logic [15:0] iter;
    logic [3:0]  run_req;
    logic [3:0]  run_busy;

    logic        s_busy, s_done, s_err;
    logic [3:0]  s_cycles;
    logic [15:0] s_iter;
    logic [0:0]  s_run_req;
    logic [0:0]  s_run_busy;

    int errors = 0;
    int checks = 0;

    int klen[NCH];
    int kcnt[NCH] = '{default: 0};
    int scnt = 0;

    int          done_at, done_n, idle_done;
    int          req_pos[$];
    int          sp1, sp2;
    logic [31:0] cap_cycles;
    logic [15:0] cap_iter;
    logic        cap_err;

    always #5 clock = ~clock;

    cfd_run_ctrl #(.NCH(NCH), .ITER_W(16), .CNT_W(32), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .ce(ce), .i_start(i_start), .i_iter(i_iter),
        .o_busy(busy), .o_done(done), .o_err(err), .o_cycles(cycles), .o_iter(iter),
        .o_run_req(run_req), .i_run_busy(run_busy)
    );

    // Narrow counter instance, used to observe saturation
    cfd_run_ctrl #(.NCH(1), .ITER_W(16), .CNT_W(4), .TIMEOUT(16)) dut_sat (
        .clock(clock), .reset(reset), .ce(ce), .i_start(i_start), .i_iter(i_iter),
        .o_busy(s_busy), .o_done(s_done), .o_err(s_err), .o_cycles(s_cycles), .o_iter(s_iter),
        .o_run_req(s_run_req), .i_run_busy(s_run_busy)
    );

    // Kernel model: busy from the cycle after req for klen enabled cycles
    always @(posedge clock) begin
        if (ce) begin
            for (int c = 0; c < NCH; c++) begin
                if (run_req[c] && klen[c] > 0) kcnt[c] <= klen[c];
                else if (kcnt[c] > 0)          kcnt[c] <= kcnt[c] - 1;
            end
            if (s_run_req[0])  scnt <= 5;
            else if (scnt > 0) scnt <= scnt - 1;
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) run_busy[c] = (kcnt[c] > 0);
        s_run_busy[0] = (scnt > 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input int n);
        i_start = 1'b1;
        i_iter  = 16'(n);
        step();
        i_start = 1'b0;
    endtask

    task automatic run_to_done(input int max, input int stray_at);
        done_at = -1;
        done_n  = 0;
        req_pos.delete();
        for (int j = 0; j < max; j++) begin
            if (run_req == 4'hF) req_pos.push_back(j);
            if (done) begin
                if (done_at < 0) begin
                    done_at    = j;
                    cap_cycles = cycles;
                    cap_iter   = iter;
                    cap_err    = err;
                end
                done_n++;
            end else if (done_at >= 0) begin
                break;
            end
            i_start = (j == stray_at);
            step();
        end
        i_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: observed=expired expected=finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        ce      = 1'b1;
        i_start = 1'b0;
        i_iter  = '0;
        klen    = '{5, 5, 5, 5};
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", run_req, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_iter", iter, 0);
        reset = 1'b0;
        step();

        // Single iteration, 5-cycle kernel: done at T+8, 7 cycles
        start_run(1);
        for (int j = 0; j <= 8; j++) begin
            chk($sformatf("s1_req_%0d", j), run_req, (j == 0) ? 4'hF : 4'h0);
            chk($sformatf("s1_done_%0d", j), done, (j == 7) ? 1 : 0);
            chk($sformatf("s1_cycles_%0d", j), cycles, (j <= 7) ? j : 7);
            chk($sformatf("s1_busy_%0d", j), busy, (j < 8) ? 1 : 0);
            step();
        end
        chk("s1_iter", iter, 1);
        chk("s1_err", err, 0);

        // Same run with ce alternating: each state spans two clocks
        start_run(1);
        for (int j = 0; j <= 16; j++) begin
            ce = j[0];
            chk($sformatf("ce_req_%0d", j), run_req, (j < 2) ? 4'hF : 4'h0);
            chk($sformatf("ce_done_%0d", j), done, (j == 14 || j == 15) ? 1 : 0);
            chk($sformatf("ce_cycles_%0d", j), cycles, (j / 2 < 7) ? j / 2 : 7);
            chk($sformatf("ce_busy_%0d", j), busy, (j < 16) ? 1 : 0);
            step();
        end
        ce = 1'b1;
        chk("ce_iter", iter, 1);

        // Three iterations, stray start in WAIT ignored
        start_run(3);
        run_to_done(60, 3);
        sp1 = (req_pos.size() >= 2) ? req_pos[1] - req_pos[0] : -1;
        sp2 = (req_pos.size() >= 3) ? req_pos[2] - req_pos[1] : -1;
        chk("it3_done_at", done_at, 21);
        chk("it3_done_n", done_n, 1);
        chk("it3_req_n", req_pos.size(), 3);
        chk("it3_space1", sp1, 7);
        chk("it3_space2", sp2, 7);
        chk("it3_cycles", cap_cycles, 21);
        chk("it3_iter", cap_iter, 3);
        chk("it3_err", cap_err, 0);
        chk("it3_idle", busy, 0);
        chk("sat_cycles", s_cycles, 15);
        chk("sat_iter", s_iter, 3);

        // Four channels, lengths 2/9/4/1: exit waits for channel 1
        klen = '{2, 9, 4, 1};
        start_run(1);
        run_to_done(60, -1);
        chk("mc_done_at", done_at, 11);
        chk("mc_cycles", cap_cycles, 11);
        chk("mc_iter", cap_iter, 1);
        chk("mc_req_n", req_pos.size(), 1);
        chk("mc_done_n", done_n, 1);

        // Zero iterations: straight to DONE, counter cleared
        start_run(0);
        chk("z_done", done, 1);
        chk("z_req", run_req, 0);
        chk("z_cycles", cycles, 0);
        chk("z_iter", iter, 0);
        chk("z_busy", busy, 1);
        step();
        chk("z_idle_busy", busy, 0);
        chk("z_idle_done", done, 0);

        // Channel 3 never goes busy
        klen = '{5, 5, 5, 0};
        start_run(1);
`ifdef RUN_CTRL_WATCHDOG_EN
        run_to_done(60, -1);
        chk("wd_done_at", done_at, 17);
        chk("wd_err", cap_err, 1);
        chk("wd_cycles", cap_cycles, 17);
        chk("wd_iter", cap_iter, 0);
        start_run(1);
`else
        idle_done = 0;
        for (int j = 0; j < 30; j++) begin
            if (done) idle_done++;
            step();
        end
        chk("nowd_done_n", idle_done, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_err", err, 0);
`endif
        repeat (3) step();
        chk("mid_busy", busy, 1);
        chk("mid_req", run_req, 0);
        reset = 1'b1;
        step();
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        chk("mr_req", run_req, 0);
        chk("mr_cycles", cycles, 0);
        chk("mr_iter", iter, 0);
        chk("mr_sat_cycles", s_cycles, 0);
        reset = 1'b0;
        step();
        chk("mr_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
